pipe_reg_mem_wb: RTL
====================

# pipe_reg_mem_wb

Parametrised MEM→WB pipeline register for the pipelined RISC-V core. It sits between the data-memory stage and the register-file write port. It carries the M-stage payload through DEPTH register stages, with stall, flush and per-entry valid tracking. It also provides an optional load-data extractor, a write-back result mux and a retired-instruction counter.

## Interface
- DATA_WIDTH, 32, datapath width (ALU result, memory read data, PC+4).
- RD_WIDTH, 5, destination register index width.
- RSRC_WIDTH, 2, ResultSrc width.
- DEPTH, 1, number of register stages between M and W; legal range is 1..4.
- CNT_WIDTH, 32, retire counter width.
- clk  in  1  clock. One clock; all state updates on its rising edge.
- rst_n  in  1  reset. Synchronous, active-low.
- Stall  in  1  hold all stages.
- Flush  in  1  insert a bubble at stage 1.
- ValidM  in  1  the M-stage entry is a real instruction.
- ALUResultM  in  DATA_WIDTH  ALU result / memory address.
- DMRd  in  DATA_WIDTH  raw data-memory read word.
- RdM  in  RD_WIDTH  destination register.
- PCPlus4M  in  DATA_WIDTH  PC+4.
- RegWriteM  in  1  register write enable.
- ResultSrcM  in  RSRC_WIDTH  write-back source select.
- Funct3M  in  3  load type.
- ValidW, RegWriteW  out  1  final-stage valid and gated write enable.
- RdW  out  RD_WIDTH.
- ResultSrcW  out  RSRC_WIDTH.
- ALUResultW, ReadDataW, PCPlus4W, ResultW  out  DATA_WIDTH.
- RetireCount  out  CNT_WIDTH  count of valid entries retired.

## Operation
- **Stages:** the block is a chain S1..S_DEPTH. Each stage holds {valid, ALUResult, ReadData, Rd, PCPlus4, RegWrite, ResultSrc}. Outputs are driven by S_DEPTH.
- **Normal cycle** (no Stall, no Flush): S1 captures the M inputs, with valid = ValidM. Each S_k captures S_(k-1).
- **Stall:** every stage holds its contents, including valid.
- **Flush without Stall:** S1 captures valid = 0 and RegWrite = 0. Data fields are don't-care and load normally. Downstream stages shift as usual.
- **Flush with Stall:** S1 valid is cleared, S1 data holds, and S2..S_DEPTH hold.
- **RegWriteW** = S_DEPTH.RegWrite AND S_DEPTH.valid. A bubble never writes the register file.
- **ResultW** (combinational from S_DEPTH), selected by ResultSrcW:
  - 00 → ALUResultW
  - 01 → ReadDataW
  - 10 → PCPlus4W
  - 11 → 0
- **RetireCount** increments by 1 on each rising edge where ValidW = 1 and Stall = 0. It wraps modulo 2^CNT_WIDTH and does not saturate.
- **Reset (rst_n = 0 at an edge):**
  - All stage valid bits and fields go to 0, and RetireCount goes to 0.
  - Reset overrides Stall and Flush.
  - Every output therefore reads 0 in the cycle after reset: ValidW = 0, RegWriteW = 0, ResultW = 0.
  - Reset asserted mid-operation discards all in-flight entries.

## Timing
- **Latency:** M inputs appear on W outputs DEPTH rising edges after capture, with no stalls. DEPTH = 1 is the classic single MEM/WB register.
- **Stalls:** each stall cycle adds one cycle of latency to every in-flight entry. No entry is lost or duplicated.
- **ResultW and RegWriteW** are combinational from the S_DEPTH flops, with zero added latency.
- **Retire counter update:** RetireCount updates on the same edge that S_DEPTH is overwritten. It counts the entry leaving W, not the one entering.
- **Load extraction** (when compiled in) is combinational ahead of S1 and adds no cycle.

## Configuration
- **Macro:** MEMWB_LOAD_EXT_EN.
- **Defined:** ReadData stored into S1 is extracted from DMRd. The lane is selected by ALUResultM[1:0] for bytes and ALUResultM[1] for halves.
  - Funct3 000 LB sign-extends the selected byte.
  - 001 LH sign-extends the selected half.
  - 100 LBU and 101 LHU zero-extend.
  - 010 LW and any other encoding pass the word unchanged.
  - A misaligned half (ALUResultM[0] = 1) uses ALUResultM[1] only.
  - DATA_WIDTH must be 32; any other value is an elaboration error.
- **Undefined:** DMRd is stored unchanged and Funct3M is ignored.

## Structure
- **Shared package `pipe_pkg`:**
  - ResultSrc encodings RSRC_ALU = 2'b00, RSRC_MEM = 2'b01, RSRC_PC4 = 2'b10.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - A packed struct type for one stage's payload.
- **Sub-module `load_extract`:** combinational, with inputs word, addr[1:0] and funct3, and output data. It is instantiated only under MEMWB_LOAD_EXT_EN.
- **Top level:** holds the stage array, the control logic, the result mux and the counter.

## Test plan
- **Basic pass-through:** DEPTH = 1; reset, then ValidM = 1, RegWriteM = 1, RdM = 5, ALUResultM = 0x00000010, ResultSrcM = 00 → next cycle RdW = 5, RegWriteW = 1, ResultW = 0x10, and RetireCount = 1 after the following edge.
- **Stall and flush:** DEPTH = 3; feed A, B, C on consecutive cycles, with Stall held for 2 cycles after B.
  - A exits on cycle 3+2, in order A, B, C, with no duplicates.
  - Flush with the capture of B → RegWriteW = 0 in B's slot and RetireCount skips it.
- **Load extraction** (macro on): DMRd = 0x80FF7F01, ALUResultM[1:0] = 01.
  - LB → 0xFFFFFF80? No — the byte at lane 1 is 0x7F, so LB → 0x0000007F.
  - Lane 2 LB → 0xFFFFFFFF; LBU → 0x000000FF.
  - ALUResultM[1:0] = 10 with LH → 0xFFFF80FF; with LHU → 0x000080FF.
- **Result mux:** ResultSrcM = 10 with PCPlus4M = 0x104 → ResultW = 0x104. ResultSrcM = 11 → ResultW = 0.
- **Mid-operation reset:** rst_n low for one edge with 3 valid entries in flight and Stall = 1 → all outputs 0 and RetireCount = 0 on the next cycle. Nothing retires afterwards without new input.
- **Counter wrap:** CNT_WIDTH = 4; retire 17 valid entries → RetireCount = 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings and payload layout for the MEM->WB pipeline register.
// The load-extract feature is controlled by MEMWB_LOAD_EXT_EN; see pipe_reg_mem_wb.
package pipe_pkg;

    localparam logic [1:0] RSRC_ALU = 2'b00;
    localparam logic [1:0] RSRC_MEM = 2'b01;
    localparam logic [1:0] RSRC_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // One stage payload at the core's native widths (32-bit datapath, 5-bit rd).
    typedef struct packed {
        logic        valid;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic        reg_write;
        logic [1:0]  result_src;
    } memwb_stage_t;

endpackage

// File: rtl/pipe_reg_mem_wb_load_extract.sv
// Combinational RV32 load lane select and sign/zero extension.
// Only compiled when MEMWB_LOAD_EXT_EN is defined.
`ifdef MEMWB_LOAD_EXT_EN
module load_extract
    import pipe_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
    end

    // A misaligned half access ignores addr[0] and takes the half picked by addr[1].
    assign half_sel = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            F3_LW:   data = word;
            default: data = word;
        endcase
    end

endmodule
`endif

// File: rtl/pipe_reg_mem_wb.sv
// MEM->WB pipeline register: DEPTH stages with stall/flush, WB result mux, retire counter.
// Define MEMWB_LOAD_EXT_EN to extract/extend load data from DMRd before stage 1.
module pipe_reg_mem_wb
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5,
    parameter int RSRC_WIDTH = 2,
    parameter int DEPTH      = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  ValidM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] DMRd,
    input  logic [RD_WIDTH-1:0]   RdM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic                  RegWriteM,
    input  logic [RSRC_WIDTH-1:0] ResultSrcM,
    input  logic [2:0]            Funct3M,
    output logic                  ValidW,
    output logic                  RegWriteW,
    output logic [RD_WIDTH-1:0]   RdW,
    output logic [RSRC_WIDTH-1:0] ResultSrcW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [DATA_WIDTH-1:0] PCPlus4W,
    output logic [DATA_WIDTH-1:0] ResultW,
    output logic [CNT_WIDTH-1:0]  RetireCount
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] read_data;
        logic [RD_WIDTH-1:0]   rd;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic                  reg_write;
        logic [RSRC_WIDTH-1:0] result_src;
    } stage_t;

    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
        $error("pipe_reg_mem_wb: DEPTH must be in 1..4");
    end

    logic [DATA_WIDTH-1:0] load_data;

`ifdef MEMWB_LOAD_EXT_EN
    if (DATA_WIDTH != 32) begin : g_width_check
        $error("pipe_reg_mem_wb: load extraction requires DATA_WIDTH == 32");
    end

    load_extract u_load_extract (
        .word   (DMRd),
        .addr   (ALUResultM[1:0]),
        .funct3 (Funct3M),
        .data   (load_data)
    );
`else
    logic unused_funct3;
    assign unused_funct3 = ^Funct3M;
    assign load_data     = DMRd;
`endif

    stage_t                 s1_next;
    stage_t                 stg [DEPTH];
    stage_t                 w_stage;
    logic [CNT_WIDTH-1:0]   retire_cnt;

    always_comb begin
        s1_next            = '0;
        s1_next.valid      = ValidM & ~Flush;
        s1_next.alu_result = ALUResultM;
        s1_next.read_data  = load_data;
        s1_next.rd         = RdM;
        s1_next.pc_plus4   = PCPlus4M;
        s1_next.reg_write  = RegWriteM & ~Flush;
        s1_next.result_src = ResultSrcM;
    end

    // Flush during a stall only kills the stage-1 entry; its payload stays put.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stg[k] <= '0;
            end
            retire_cnt <= '0;
        end else begin
            if (!Stall) begin
                stg[0] <= s1_next;
                for (int k = 1; k < DEPTH; k++) begin
                    stg[k] <= stg[k-1];
                end
            end else if (Flush) begin
                stg[0].valid <= 1'b0;
            end
            if (stg[DEPTH-1].valid && !Stall) begin
                retire_cnt <= retire_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign w_stage     = stg[DEPTH-1];
    assign ValidW      = w_stage.valid;
    assign RegWriteW   = w_stage.reg_write & w_stage.valid;
    assign RdW         = w_stage.rd;
    assign ResultSrcW  = w_stage.result_src;
    assign ALUResultW  = w_stage.alu_result;
    assign ReadDataW   = w_stage.read_data;
    assign PCPlus4W    = w_stage.pc_plus4;
    assign RetireCount = retire_cnt;

    always_comb begin
        ResultW = '0;
        case (w_stage.result_src)
            RSRC_WIDTH'(RSRC_ALU): ResultW = w_stage.alu_result;
            RSRC_WIDTH'(RSRC_MEM): ResultW = w_stage.read_data;
            RSRC_WIDTH'(RSRC_PC4): ResultW = w_stage.pc_plus4;
            default:               ResultW = '0;
        endcase
    end

endmodule
